// File: rtl/lfsr_operand_gen.sv
// Seeded Galois-LFSR operand source: emits a programmed number of (a,b) pairs
// over a valid/ready handshake, then pulses done for one cycle.
module lfsr_operand_gen #(
    parameter int                     WIDTH   = 8,
    parameter logic [2*WIDTH-1:0]     POLY    = 16'hB400,
    parameter int                     COUNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   seed,
    input  logic [COUNT_W-1:0]   num_pairs,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 valid,
    input  logic                 ready,
    output logic [COUNT_W-1:0]   pair_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int                 LW       = 2 * WIDTH;
    localparam logic [LW-1:0]      LFSR_ONE = LW'(1);
    localparam logic [LW-1:0]      LFSR_ZRO = LW'(0);
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ZRO  = COUNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [LW-1:0]       lfsr_r, lfsr_s;
    logic [COUNT_W-1:0]  cnt_r, cnt_s;
    logic [COUNT_W-1:0]  pair_idx_r, pair_idx_s;
    logic [WIDTH-1:0]    a_r, b_r;
    logic                valid_r, busy_r, done_r;

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : LFSR_ZRO);
    endfunction

    // Next-state, LFSR, counter and index logic.
    always_comb begin
        state_s    = state_r;
        lfsr_s     = lfsr_r;
        cnt_s      = cnt_r;
        pair_idx_s = pair_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    // A zero seed would lock the LFSR at zero forever.
                    lfsr_s     = (seed == LFSR_ZRO) ? LFSR_ONE : seed;
                    cnt_s      = num_pairs;
                    pair_idx_s = CNT_ZRO;
                    state_s    = (num_pairs == CNT_ZRO) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (valid_r && ready) begin
                    pair_idx_s = pair_idx_r + CNT_ONE;
                    cnt_s      = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_s = ST_DONE;
                    end else begin
                        lfsr_s = lfsr_step(lfsr_r);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs, all derived from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            lfsr_r     <= LFSR_ONE;
            cnt_r      <= CNT_ZRO;
            pair_idx_r <= CNT_ZRO;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            lfsr_r     <= lfsr_s;
            cnt_r      <= cnt_s;
            pair_idx_r <= pair_idx_s;
            a_r        <= lfsr_s[LW-1:WIDTH];
            b_r        <= lfsr_s[WIDTH-1:0];
            valid_r    <= (state_s == ST_RUN);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
        end
    end

    assign a        = a_r;
    assign b        = b_r;
    assign valid    = valid_r;
    assign pair_idx = pair_idx_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_lfsr_operand_gen.sv
// Directed bench for lfsr_operand_gen: reset, known sequence, backpressure,
// edge seeds/counts, back-to-back start, mid-run reset and a long random-ready run.
module tb_lfsr_operand_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] seed;
    logic [7:0]  num_pairs;
    logic [7:0]  a, b;
    logic        valid;
    logic        ready;
    logic [7:0]  pair_idx;
    logic        busy;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    lfsr_operand_gen #(.WIDTH(8), .POLY(16'hB400), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .num_pairs(num_pairs), .a(a), .b(b), .valid(valid), .ready(ready),
        .pair_idx(pair_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Leaves the bench at the falling edge after start was accepted.
    task automatic do_start(input logic [15:0] sd, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1; seed = sd; num_pairs = n;
        @(negedge clk);
        start = 1'b0; seed = 16'h5555; num_pairs = 8'hAA;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1)); ready = 1'($urandom_range(0, 1));
            seed = 16'($urandom); num_pairs = 8'($urandom);
            tests_run++;
            if ({valid, busy, done, a, b, pair_idx} !== 27'd0) begin
                tests_failed++;
                $display("FAIL reset: got v=%b busy=%b done=%b a=%h b=%h idx=%0d, want all 0",
                         valid, busy, done, a, b, pair_idx);
            end
        end
        start = 1'b0; ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_known_sequence();
        logic [7:0] ea [4] = '{8'h00, 8'hB4, 8'h5A, 8'h2D};
        logic [7:0] eb [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
        ready = 1'b1;
        do_start(16'h0001, 8'd4);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({valid, a, b} !== {1'b1, ea[i], eb[i]}) begin
                tests_failed++;
                $display("FAIL known_pair%0d: got v=%b (%h,%h), want v=1 (%h,%h)",
                         i, valid, a, b, ea[i], eb[i]);
            end
            @(negedge clk);
        end
        tests_run++;
        if ({done, valid, busy, pair_idx} !== {1'b1, 1'b0, 1'b1, 8'd4}) begin
            tests_failed++;
            $display("FAIL known_done: got done=%b v=%b busy=%b idx=%0d, want 1 0 1 4",
                     done, valid, busy, pair_idx);
        end
        @(negedge clk);
        tests_run++;
        if ({done, busy, pair_idx} !== {1'b0, 1'b0, 8'd4}) begin
            tests_failed++;
            $display("FAIL known_idle: got done=%b busy=%b idx=%0d, want 0 0 4",
                     done, busy, pair_idx);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ea [4] = '{8'h00, 8'hB4, 8'h5A, 8'h2D};
        int xfers = 0;
        int k     = 0;
        int stall = 0;
        ready = 1'b1;
        do_start(16'h0001, 8'd4);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            ready = !(k == 1 && stall < 3);
            if (k == 1 && stall < 3) stall++;
            tests_run++;
            if ({valid, a, b} !== {1'b1, ea[k], (k == 0) ? 8'h01 : 8'h00}) begin
                tests_failed++;
                $display("FAIL bp_pair%0d cyc%0d: got v=%b (%h,%h), want v=1 (%h,--)",
                         k, cyc, valid, a, b, ea[k]);
            end
            if (valid && ready) begin
                xfers++;
                k = (k < 3) ? k + 1 : 3;
            end
            @(negedge clk);
        end
        tests_run++;
        if ({done, pair_idx} !== {1'b1, 8'd4} || xfers != 4 || stall != 3) begin
            tests_failed++;
            $display("FAIL bp_total: got done=%b idx=%0d xfers=%0d stalls=%0d, want 1 4 4 3",
                     done, pair_idx, xfers, stall);
        end
    endtask

    task automatic test_edge_seed_count();
        ready = 1'b1;
        do_start(16'h0000, 8'd1);
        tests_run++;
        if ({valid, a, b} !== {1'b1, 8'h00, 8'h01}) begin
            tests_failed++;
            $display("FAIL seed0_pair: got v=%b (%h,%h), want v=1 (00,01)", valid, a, b);
        end
        @(negedge clk);
        tests_run++;
        if ({done, pair_idx} !== {1'b1, 8'd1}) begin
            tests_failed++;
            $display("FAIL seed0_done: got done=%b idx=%0d, want 1 1", done, pair_idx);
        end
        do_start(16'h1234, 8'd0);
        tests_run++;
        if ({valid, done, busy, pair_idx} !== {1'b0, 1'b1, 1'b1, 8'd0}) begin
            tests_failed++;
            $display("FAIL zero_pairs_done: got v=%b done=%b busy=%b idx=%0d, want 0 1 1 0",
                     valid, done, busy, pair_idx);
        end
        @(negedge clk);
        tests_run++;
        if ({valid, done, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL zero_pairs_idle: got v=%b done=%b busy=%b, want 0 0 0",
                     valid, done, busy);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        do_start(16'h0005, 8'd1);
        tests_run++;
        if ({valid, a, b} !== {1'b1, 8'h00, 8'h05}) begin
            tests_failed++;
            $display("FAIL b2b_first: got v=%b (%h,%h), want v=1 (00,05)", valid, a, b);
        end
        @(negedge clk);
        // Start raised during DONE is ignored; held into IDLE it is accepted.
        start = 1'b1; seed = 16'h0001; num_pairs = 8'd2;
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done: got done=%b, want 1", done);
        end
        @(negedge clk);
        tests_run++;
        if ({valid, done, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL b2b_ignored_in_done: got v=%b done=%b busy=%b, want 0 0 0",
                     valid, done, busy);
        end
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({valid, a, b, pair_idx} !== {1'b1, 8'h00, 8'h01, 8'd0}) begin
            tests_failed++;
            $display("FAIL b2b_restart: got v=%b (%h,%h) idx=%0d, want v=1 (00,01) idx=0",
                     valid, a, b, pair_idx);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int saw_done = 0;
        ready = 1'b1;
        do_start(16'h0001, 8'd10);
        repeat (3) @(negedge clk);
        tests_run++;
        if ({valid, pair_idx} !== {1'b1, 8'd3}) begin
            tests_failed++;
            $display("FAIL midrst_pre: got v=%b idx=%0d, want 1 3", valid, pair_idx);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({valid, busy, done, a, b, pair_idx} !== 27'd0) begin
            tests_failed++;
            $display("FAIL midrst_async: got v=%b busy=%b done=%b a=%h b=%h idx=%0d, want all 0",
                     valid, busy, done, a, b, pair_idx);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || valid || busy) saw_done++;
        end
        tests_run++;
        if (saw_done != 0) begin
            tests_failed++;
            $display("FAIL midrst_no_done: got %0d active cycles, want 0", saw_done);
        end
        do_start(16'h0001, 8'd2);
        tests_run++;
        if ({valid, a, b} !== {1'b1, 8'h00, 8'h01}) begin
            tests_failed++;
            $display("FAIL midrst_restart: got v=%b (%h,%h), want v=1 (00,01)", valid, a, b);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_long_run();
        logic [15:0] s = 16'hACE1;
        bit          seen [65536];
        int          xfers = 0;
        int          cyc   = 0;
        int          bad   = 0;
        do_start(16'hACE1, 8'd255);
        while (!done && cyc < 3000) begin
            if (valid) begin
                if ({a, b} !== s) begin
                    bad++;
                    if (bad <= 5)
                        $display("FAIL long_pair%0d: got %h%h, want %h", xfers, a, b, s);
                end
                ready = 1'($urandom_range(0, 1));
                if (ready) begin
                    if (seen[{a, b}]) begin
                        bad++;
                        $display("FAIL long_repeat: state %h%h seen twice", a, b);
                    end
                    seen[{a, b}] = 1'b1;
                    xfers++;
                    s = model_step(s);
                end
            end else begin
                ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL long_sequence: got %0d bad pairs, want 0", bad);
        end
        tests_run++;
        if ({done, pair_idx} !== {1'b1, 8'd255} || xfers != 255) begin
            tests_failed++;
            $display("FAIL long_count: got done=%b idx=%0d xfers=%0d cyc=%0d, want 1 255 255",
                     done, pair_idx, xfers, cyc);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0;
        seed = 16'h0000; num_pairs = 8'd0;
        test_reset();
        test_known_sequence();
        test_backpressure();
        test_edge_seed_count();
        test_back_to_back();
        test_reset_mid_run();
        test_long_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
